// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Optional performance counters in fetch_stage are built when FETCH_PERF_CNT_EN is defined.
package fetch_pkg;

  localparam int          IW_DEFAULT       = 16;
  localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;
  localparam int          PC_INC           = 2;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2,
    ST_DROP = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with a one-word hold buffer for responses that
// arrive while decode is stalled on a live instruction.
module if_id_reg
  import fetch_pkg::*;
#(
  parameter int IW = IW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  input  logic          load_rsp,
  input  logic          load_buf,
  input  logic          cap_rsp,
  input  logic [IW-1:0] rsp_data,
  input  logic [IW-1:0] load_pc,
  input  logic [IW-1:0] load_pc_plus2,
  output logic          load_en,
  output logic          if_valid,
  output logic [IW-1:0] if_instr,
  output logic [IW-1:0] if_pc,
  output logic [IW-1:0] if_pc_plus2
);

  logic          valid_q, valid_d;
  logic [IW-1:0] instr_q, instr_d;
  logic [IW-1:0] pc_q, pc_d;
  logic [IW-1:0] plus2_q, plus2_d;
  logic [IW-1:0] hold_q, hold_d;

  always_comb begin
    load_en = !valid_q || !stall;
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    plus2_d = plus2_q;
    hold_d  = hold_q;
    if (flush) begin
      valid_d = 1'b0;
      hold_d  = '0;
    end else if (load_rsp) begin
      valid_d = 1'b1;
      instr_d = rsp_data;
      pc_d    = load_pc;
      plus2_d = load_pc_plus2;
    end else if (load_buf) begin
      valid_d = 1'b1;
      instr_d = hold_q;
      pc_d    = load_pc;
      plus2_d = load_pc_plus2;
      hold_d  = '0;
    end else begin
      if (cap_rsp) hold_d = rsp_data;
      // Consumed (or already empty) with nothing arriving: the slot goes empty.
      if (load_en) valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
      plus2_q <= '0;
      hold_q  <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      plus2_q <= plus2_d;
      hold_q  <= hold_d;
    end
  end

  assign if_valid    = valid_q;
  assign if_instr    = instr_q;
  assign if_pc       = pc_q;
  assign if_pc_plus2 = plus2_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: request FSM and PC, feeding the IF/ID register.
// Define FETCH_PERF_CNT_EN to add saturating fetch_cnt / redirect_cnt outputs.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int            IW       = IW_DEFAULT,
  parameter logic [IW-1:0] RESET_PC = IW'(RESET_PC_DEFAULT)
) (
  input  logic          clk,
  input  logic          rst,
  output logic          imem_req,
  output logic [IW-1:0] imem_addr,
  input  logic          imem_rvalid,
  input  logic [IW-1:0] imem_rdata,
  input  logic          redirect_valid,
  input  logic [IW-1:0] redirect_pc,
  input  logic          stall,
  output logic          if_valid,
  output logic [IW-1:0] if_instr,
  output logic [IW-1:0] if_pc,
  output logic [IW-1:0] if_pc_plus2
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [IW-1:0] fetch_cnt,
  output logic [IW-1:0] redirect_cnt
`endif
);

  fetch_state_e  state_q, state_d;
  logic [IW-1:0] pc_q, pc_d;
  logic          imem_req_q, imem_req_d;
  logic [IW-1:0] imem_addr_q;
  logic [IW-1:0] pc_inc;
  logic          load_en;
  logic          load_rsp;
  logic          load_buf;
  logic          cap_rsp;

  assign pc_inc = pc_q + IW'(PC_INC);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    load_rsp = 1'b0;
    load_buf = 1'b0;
    cap_rsp  = 1'b0;
    case (state_q)
      // A response seen here belongs to a request abandoned by reset.
      ST_REQ: state_d = redirect_valid ? ST_DROP : ST_WAIT;
      ST_WAIT: begin
        if (redirect_valid) begin
          state_d = imem_rvalid ? ST_REQ : ST_DROP;
        end else if (imem_rvalid) begin
          if (load_en) begin
            load_rsp = 1'b1;
            pc_d     = pc_inc;
            state_d  = ST_REQ;
          end else begin
            cap_rsp = 1'b1;
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (redirect_valid) begin
          state_d = ST_REQ;
        end else if (load_en) begin
          load_buf = 1'b1;
          pc_d     = pc_inc;
          state_d  = ST_REQ;
        end
      end
      ST_DROP: if (imem_rvalid) state_d = ST_REQ;
      default: state_d = ST_REQ;
    endcase
    if (redirect_valid) pc_d = redirect_pc;
    imem_req_d = (state_d == ST_REQ);
  end

  // Request strobe and address are registered off the next-state values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_REQ;
      pc_q        <= RESET_PC;
      imem_req_q  <= 1'b1;
      imem_addr_q <= RESET_PC;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      imem_req_q  <= imem_req_d;
      imem_addr_q <= pc_d;
    end
  end

  assign imem_req  = imem_req_q;
  assign imem_addr = imem_addr_q;

  if_id_reg #(
    .IW(IW)
  ) u_if_id (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .flush        (redirect_valid),
    .load_rsp     (load_rsp),
    .load_buf     (load_buf),
    .cap_rsp      (cap_rsp),
    .rsp_data     (imem_rdata),
    .load_pc      (pc_q),
    .load_pc_plus2(pc_inc),
    .load_en      (load_en),
    .if_valid     (if_valid),
    .if_instr     (if_instr),
    .if_pc        (if_pc),
    .if_pc_plus2  (if_pc_plus2)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [IW-1:0] fetch_cnt_q, fetch_cnt_d;
  logic [IW-1:0] redirect_cnt_q, redirect_cnt_d;

  always_comb begin
    fetch_cnt_d    = fetch_cnt_q;
    redirect_cnt_d = redirect_cnt_q;
    if ((load_rsp || load_buf) && (fetch_cnt_q != '1)) fetch_cnt_d = fetch_cnt_q + IW'(1);
    if (redirect_valid && (redirect_cnt_q != '1)) redirect_cnt_d = redirect_cnt_q + IW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q    <= '0;
      redirect_cnt_q <= '0;
    end else begin
      fetch_cnt_q    <= fetch_cnt_d;
      redirect_cnt_q <= redirect_cnt_d;
    end
  end

  assign fetch_cnt    = fetch_cnt_q;
  assign redirect_cnt = redirect_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a memory responder plus an instruction-stream model
// (the decoder must see consecutive PCs, restarting at every redirect target).
module tb_fetch_stage;

  localparam logic [15:0] RST_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        stall;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic [15:0] if_pc_plus2;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_cnt;
  logic [15:0] redirect_cnt;
`endif

  always #5 clk = ~clk;

  fetch_stage #(
    .IW      (16),
    .RESET_PC(RST_PC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .stall         (stall),
    .if_valid      (if_valid),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .if_pc_plus2   (if_pc_plus2)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt     (fetch_cnt),
    .redirect_cnt  (redirect_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  // memory responder state
  bit          pend;
  logic [15:0] pend_addr;
  int          pend_cnt;
  int          lat_min;
  int          lat_max;

  // instruction-stream model state
  logic [15:0] exp_pc;
  bit          prev_rd;
  bit          addr_chk;
  logic [15:0] addr_exp;
  int          consumed;
  int          idle;

  // outputs sampled in the most recent cycle
  logic        s_req;
  logic        s_valid;
  logic [15:0] s_addr;
  logic [15:0] s_instr;
  logic [15:0] s_pc;
  logic [15:0] s_plus2;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [15:0] p;
    if (a == 16'h0100) return 16'hABCD;
    p = a * 16'h9E37;
    return p ^ 16'h1234;
  endfunction

  // One clock cycle: sample outputs, play memory, drive inputs, check the stream.
  task automatic tick(input bit st, input bit rd, input logic [15:0] rpc, input bit rs);
    logic [15:0] e_p2;
    @(negedge clk);
    s_req   = imem_req;
    s_valid = if_valid;
    s_addr  = imem_addr;
    s_instr = if_instr;
    s_pc    = if_pc;
    s_plus2 = if_pc_plus2;

    imem_rvalid = 1'b0;
    imem_rdata  = 16'h0000;
    if (pend) begin
      if (pend_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(pend_addr);
        pend        = 1'b0;
      end else begin
        pend_cnt--;
      end
    end
    if (imem_req === 1'b1 && !rs) begin
      checks++;
      if (pend) $display("FAIL one_outstanding: got 2 requests outstanding expected 1 (addr %h)", imem_addr);
      if (pend) errors++;
      if (addr_chk) begin
        checks++;
        if (imem_addr !== addr_exp) begin
          errors++;
          $display("FAIL redirect_addr: got %h expected %h", imem_addr, addr_exp);
        end
        addr_chk = 1'b0;
      end
      pend      = 1'b1;
      pend_addr = imem_addr;
      pend_cnt  = $urandom_range(lat_max, lat_min) - 1;
    end

    stall          = st;
    redirect_valid = rd;
    redirect_pc    = rpc;
    rst            = rs;

    if (rs) begin
      exp_pc   = RST_PC;
      prev_rd  = 1'b0;
      addr_chk = 1'b0;
      idle     = 0;
    end else begin
      if (prev_rd) begin
        checks++;
        if (if_valid !== 1'b0) begin
          errors++;
          $display("FAIL flush_valid: got %b expected 0", if_valid);
        end
      end
      if (if_valid === 1'b1) begin
        e_p2 = exp_pc + 16'd2;
        checks += 3;
        if (if_pc !== exp_pc) begin
          errors++;
          $display("FAIL stream_pc: got %h expected %h", if_pc, exp_pc);
        end
        if (if_instr !== mem_word(exp_pc)) begin
          errors++;
          $display("FAIL stream_instr: got %h expected %h", if_instr, mem_word(exp_pc));
        end
        if (if_pc_plus2 !== e_p2) begin
          errors++;
          $display("FAIL stream_pc_plus2: got %h expected %h", if_pc_plus2, e_p2);
        end
        if (!st && !rd) begin
          $display("txn %0d pc=%h instr=%h", consumed, if_pc, if_instr);
          consumed++;
          exp_pc = exp_pc + 16'd2;
        end
        idle = 0;
      end else begin
        idle++;
      end
      checks++;
      if (idle >= 60) begin
        errors++;
        $display("FAIL liveness: got %0d idle cycles expected < 60", idle);
        idle = 0;
      end
      if (rd) begin
        exp_pc   = rpc;
        addr_chk = 1'b1;
        addr_exp = rpc;
      end
      prev_rd = rd;
    end
    @(posedge clk);
  endtask

  task automatic test_reset();
    lat_min = 1;
    lat_max = 1;
    tick(0, 0, 16'h0, 1);
    tick(0, 0, 16'h0, 1);
    tick(0, 0, 16'h0, 0);
    checks += 6;
    if (s_req !== 1'b1) begin errors++; $display("FAIL reset_req: got %b expected 1", s_req); end
    if (s_addr !== RST_PC) begin errors++; $display("FAIL reset_addr: got %h expected %h", s_addr, RST_PC); end
    if (s_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", s_valid); end
    if (s_instr !== 16'h0) begin errors++; $display("FAIL reset_instr: got %h expected 0000", s_instr); end
    if (s_pc !== 16'h0) begin errors++; $display("FAIL reset_pc: got %h expected 0000", s_pc); end
    if (s_plus2 !== 16'h0) begin errors++; $display("FAIL reset_plus2: got %h expected 0000", s_plus2); end
  endtask

  task automatic test_first_fetch();
    tick(0, 0, 16'h0, 0);
    checks++;
    if (s_req !== 1'b0) begin errors++; $display("FAIL first_wait_req: got %b expected 0", s_req); end
    tick(0, 0, 16'h0, 0);
    checks += 5;
    if (s_valid !== 1'b1) begin errors++; $display("FAIL first_valid: got %b expected 1", s_valid); end
    if (s_instr !== 16'h1234) begin errors++; $display("FAIL first_instr: got %h expected 1234", s_instr); end
    if (s_pc !== 16'h0000) begin errors++; $display("FAIL first_pc: got %h expected 0000", s_pc); end
    if (s_plus2 !== 16'h0002) begin errors++; $display("FAIL first_plus2: got %h expected 0002", s_plus2); end
    if (s_req !== 1'b1 || s_addr !== 16'h0002) begin
      errors++;
      $display("FAIL second_req: got req=%b addr=%h expected req=1 addr=0002", s_req, s_addr);
    end
  endtask

  task automatic test_stall_hold();
    bit found = 1'b0;
    lat_min = 1;
    lat_max = 1;
    tick(1, 1, 16'h00FE, 0);
    for (int i = 0; i < 20 && !found; i++) begin
      tick(1, 0, 16'h0, 0);
      found = (s_valid === 1'b1) && (s_pc === 16'h00FE);
    end
    checks++;
    if (!found) begin errors++; $display("FAIL hold_setup: got timeout expected pc 00fe in IF/ID"); end
    for (int i = 0; i < 3; i++) begin
      tick(i < 2, 0, 16'h0, 0);
      checks += 2;
      if (s_req !== 1'b0) begin errors++; $display("FAIL hold_no_req: got %b expected 0", s_req); end
      if (s_pc !== 16'h00FE) begin errors++; $display("FAIL hold_ifid: got %h expected 00fe", s_pc); end
    end
    tick(1, 0, 16'h0, 0);
    checks += 3;
    if (s_instr !== 16'hABCD) begin errors++; $display("FAIL hold_release_instr: got %h expected abcd", s_instr); end
    if (s_pc !== 16'h0100) begin errors++; $display("FAIL hold_release_pc: got %h expected 0100", s_pc); end
    if (s_req !== 1'b1 || s_addr !== 16'h0102) begin
      errors++;
      $display("FAIL hold_next_req: got req=%b addr=%h expected req=1 addr=0102", s_req, s_addr);
    end
    tick(0, 0, 16'h0, 0);
  endtask

  task automatic test_redirect_wait();
    bit found = 1'b0;
    lat_min = 3;
    lat_max = 3;
    for (int i = 0; i < 20 && !found; i++) begin
      tick(0, 0, 16'h0, 0);
      found = (s_req === 1'b1);
    end
    tick(0, 1, 16'h0040, 0);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick(0, 0, 16'h0, 0);
      found = (s_req === 1'b1);
    end
    checks++;
    if (!found || s_addr !== 16'h0040) begin
      errors++;
      $display("FAIL drop_then_req: got found=%b addr=%h expected addr 0040", found, s_addr);
    end
  endtask

  task automatic test_redirect_rvalid();
    bit found = 1'b0;
    lat_min = 1;
    lat_max = 1;
    for (int i = 0; i < 20 && !found; i++) begin
      tick(0, 0, 16'h0, 0);
      found = (s_req === 1'b1);
    end
    tick(0, 1, 16'h0080, 0);
    tick(0, 0, 16'h0, 0);
    checks++;
    if (s_req !== 1'b1 || s_addr !== 16'h0080) begin
      errors++;
      $display("FAIL redirect_no_drop: got req=%b addr=%h expected req=1 addr=0080", s_req, s_addr);
    end
  endtask

  task automatic test_wrap();
    bit found = 1'b0;
    lat_min = 1;
    lat_max = 1;
    tick(0, 1, 16'hFFFE, 0);
    for (int i = 0; i < 20 && !found; i++) begin
      tick(0, 0, 16'h0, 0);
      found = (s_valid === 1'b1) && (s_pc === 16'hFFFE);
    end
    checks += 2;
    if (!found || s_plus2 !== 16'h0000) begin
      errors++;
      $display("FAIL wrap_plus2: got found=%b plus2=%h expected 0000", found, s_plus2);
    end
    if (s_req !== 1'b1 || s_addr !== 16'h0000) begin
      errors++;
      $display("FAIL wrap_addr: got req=%b addr=%h expected req=1 addr=0000", s_req, s_addr);
    end
  endtask

  task automatic test_reset_mid_wait();
    bit found = 1'b0;
    lat_min = 3;
    lat_max = 3;
    for (int i = 0; i < 40 && !found; i++) begin
      tick(0, 0, 16'h0, 0);
      found = (s_req === 1'b1) && (s_addr !== RST_PC);
    end
    tick(0, 0, 16'h0, 1);
    pend_cnt = 0;
    lat_min  = 1;
    lat_max  = 1;
    tick(0, 0, 16'h0, 0);
    checks++;
    if (s_req !== 1'b1 || s_addr !== RST_PC || imem_rvalid !== 1'b1) begin
      errors++;
      $display("FAIL late_rvalid_setup: got req=%b addr=%h rvalid=%b expected 1 %h 1", s_req, s_addr, imem_rvalid, RST_PC);
    end
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick(0, 0, 16'h0, 0);
      found = (s_valid === 1'b1);
    end
    checks++;
    if (!found || s_pc !== RST_PC || s_instr !== mem_word(RST_PC)) begin
      errors++;
      $display("FAIL reset_first_pc: got pc=%h instr=%h expected pc=%h instr=%h", s_pc, s_instr, RST_PC, mem_word(RST_PC));
    end
  endtask

  task automatic test_random();
    int          start;
    logic [15:0] r;
    start   = consumed;
    lat_min = 1;
    lat_max = 4;
    for (int i = 0; i < 800; i++) begin
      r    = 16'($urandom);
      r[0] = 1'b0;
      tick($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 4, r, 0);
    end
    for (int i = 0; i < 10; i++) tick(0, 0, 16'h0, 0);
    checks++;
    if (consumed - start < 50) begin
      errors++;
      $display("FAIL random_throughput: got %0d instructions expected >= 50", consumed - start);
    end
  endtask

  initial begin
    rst            = 1'b1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0;
    imem_rvalid    = 1'b0;
    imem_rdata     = 16'h0;
    pend           = 1'b0;
    pend_addr      = 16'h0;
    pend_cnt       = 0;
    exp_pc         = RST_PC;
    prev_rd        = 1'b0;
    addr_chk       = 1'b0;
    addr_exp       = 16'h0;
    consumed       = 0;
    idle           = 0;
    test_reset();
    test_first_fetch();
    test_stall_hold();
    test_redirect_wait();
    test_redirect_rvalid();
    test_wrap();
    test_reset_mid_wait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
